id_ex_stage: RTL and testbench

- Decode-to-execute pipeline register and interlock unit, directly downstream of the instruction controller.
- Latches the def::ctrl word with operands, resolves the write-destination register and the extended immediate, and inserts bubbles for load-use hazards and multiply-unit occupancy.
- Honours a downstream hold and a branch/jump flush from EX.

---
 rtl/id_ex_stage_pkg.sv | 75 +++++++
 rtl/id_ex_stage_hazard.sv | 49 ++++
 rtl/id_ex_stage.sv | 92 +++++++++
 tb/tb_id_ex_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Package def: decoded control word, ID/EX register bank type, field-select
// constants and the helpers that resolve the write address and extended
// immediate.
package def;

  // 31-bit decoded control word produced by the instruction controller.
  typedef struct packed {
    logic       WRITE_REG;    // instruction writes the register file
    logic       WRITE_MEM;    // store
    logic       ALUORMEM_WR;  // 1 = write-back data comes from memory
    logic       MULTIPLY;     // uses the multiply unit
    logic       BRANCH;
    logic       JUMP;
    logic       JUMP_REG;
    logic       LINK;
    logic [1:0] REG_DST;      // write-address select
    logic [1:0] IMMED_EXT;    // immediate extension mode
    logic       ALU_SRC;
    logic [3:0] ALU_OP;
    logic       SHIFT_VAR;
    logic [1:0] MEM_SIZE;
    logic       MEM_SIGNED;
    logic [2:0] BRANCH_TYPE;
    logic       MFHI;
    logic       MFLO;
    logic       SIGNED_MUL;
    logic       SYSCALL;
    logic       BREAK;
    logic       MOVE_HILO;
    logic       ILLEGAL;
  } ctrl;

  // Contents of the ID/EX pipeline register. All-zero is a bubble.
  typedef struct packed {
    ctrl         ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wa;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        valid;
  } ex_regs;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] IMM_ZERO  = 2'b00;
  localparam logic [1:0] IMM_SIGN  = 2'b01;
  localparam logic [1:0] IMM_UPPER = 2'b10;

  localparam logic [4:0] REG_RA = 5'd31;

  // REG_DST 1x selects the link register.
  function automatic logic [4:0] resolve_wa(input logic [1:0] sel,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd);
    if (sel[1])                 return REG_RA;
    else if (sel == REG_DST_RD) return rd;
    else                        return rt;
  endfunction

  // Encoding 11 is unused and treated as zero-extend.
  function automatic logic [31:0] extend_imm(input logic [1:0]  ext,
                                             input logic [15:0] imm);
    case (ext)
      IMM_SIGN:  return {{16{imm[15]}}, imm};
      IMM_UPPER: return {imm, 16'h0000};
      default:   return {16'h0000, imm};
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard.sv
// hazard_unit: load-use and multiply-occupancy interlocks for the ID/EX stage.
//   in : clk, reset, id_valid, id_mul, id_rs, id_rt   - instruction in ID
//        ex_valid, ex_load, ex_wa                      - instruction in EX
//        ex_hold, flush                                - downstream controls
//   out: load_use, mul_block, stall_id, mul_busy
module hazard_unit #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic       id_mul,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_valid,
  input  logic       ex_load,
  input  logic [4:0] ex_wa,
  input  logic       ex_hold,
  input  logic       flush,
  output logic       load_use,
  output logic       mul_block,
  output logic       stall_id,
  output logic       mul_busy
);

  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);

  logic [CW-1:0] cnt;
  logic          mul_issue;

  // A bubble in EX carries ex_valid = 0, so a load-use stall self-clears.
  assign load_use  = ex_valid & ex_load & (ex_wa != 5'd0) & id_valid &
                     ((ex_wa == id_rs) | (ex_wa == id_rt));
  assign mul_busy  = (cnt != '0);
  assign mul_block = id_valid & id_mul & mul_busy;
  assign stall_id  = ex_hold | load_use | mul_block;

  // Only an accepted multiply arms the counter; flush after issue does not
  // cancel it because the unit is already running.
  assign mul_issue = id_valid & id_mul & ~flush & ~ex_hold & ~load_use & ~mul_block;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cnt <= '0;
    else if (mul_issue) cnt <= CNT_LOAD;
    else if (mul_busy)  cnt <= cnt - CW'(1);
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with interlocks.
//   in : clk, reset, id_valid, id_ctrl, id_rs/rt/rd, id_rs_val/rt_val,
//        id_immed, id_pc, ex_hold, flush
//   out: stall_id, ex_valid, ex_ctrl, ex_rs, ex_rt, ex_wa, ex_rs_val,
//        ex_rt_val, ex_imm, ex_pc, mul_busy
// Update priority: flush > ex_hold > interlock bubble > accept.
module id_ex_stage
  import def::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  ctrl         id_ctrl,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [15:0] id_immed,
  input  logic [31:0] id_pc,
  input  logic        ex_hold,
  input  logic        flush,
  output logic        stall_id,
  output logic        ex_valid,
  output ctrl         ex_ctrl,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_wa,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc,
  output logic        mul_busy
);

  ex_regs r, acc;
  logic   load_use, mul_block;

  hazard_unit #(.MUL_LAT(MUL_LAT)) u_hazard (
    .clk      (clk),
    .reset    (reset),
    .id_valid (id_valid),
    .id_mul   (id_ctrl.MULTIPLY),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .ex_valid (r.valid),
    .ex_load  (r.ctrl.WRITE_REG & r.ctrl.ALUORMEM_WR),
    .ex_wa    (r.wa),
    .ex_hold  (ex_hold),
    .flush    (flush),
    .load_use (load_use),
    .mul_block(mul_block),
    .stall_id (stall_id),
    .mul_busy (mul_busy)
  );

  always_comb begin
    acc        = '0;
    acc.valid  = 1'b1;
    acc.ctrl   = id_ctrl;
    acc.rs     = id_rs;
    acc.rt     = id_rt;
    acc.wa     = resolve_wa(id_ctrl.REG_DST, id_rt, id_rd);
    acc.rs_val = id_rs_val;
    acc.rt_val = id_rt_val;
    acc.imm    = extend_imm(id_ctrl.IMMED_EXT, id_immed);
    acc.pc     = id_pc;
  end

  // Flush wins over hold: the instruction in EX is dead even if EX is frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     r <= '0;
    else if (flush)                                r <= '0;
    else if (!ex_hold) begin
      if (load_use || mul_block || !id_valid)      r <= '0;
      else                                         r <= acc;
    end
  end

  assign ex_valid  = r.valid;
  assign ex_ctrl   = r.ctrl;
  assign ex_rs     = r.rs;
  assign ex_rt     = r.rt;
  assign ex_wa     = r.wa;
  assign ex_rs_val = r.rs_val;
  assign ex_rt_val = r.rt_val;
  assign ex_imm    = r.imm;
  assign ex_pc     = r.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes expected stall_id and
// expected post-edge EX contents; two monitors pop and compare.
module tb_id_ex_stage;
  import def::*;

  localparam int MUL_LAT = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        id_valid = 1'b0;
  ctrl         id_ctrl = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [31:0] id_rs_val = '0, id_rt_val = '0, id_pc = '0;
  logic [15:0] id_immed = '0;
  logic        ex_hold = 1'b0, flush = 1'b0;
  logic        stall_id, ex_valid, mul_busy;
  ctrl         ex_ctrl;
  logic [4:0]  ex_rs, ex_rt, ex_wa;
  logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc;

  id_ex_stage #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_val(id_rs_val),
    .id_rt_val(id_rt_val), .id_immed(id_immed), .id_pc(id_pc),
    .ex_hold(ex_hold), .flush(flush), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wa(ex_wa), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  logic   stall_q[$];
  ex_regs ex_q[$];
  logic   busy_q[$];

  // Reference state: what EX should hold, and when the last multiply issued
  // (counted in clock edges).
  ex_regs m;
  int     edges = 0;
  int     last_mul = -1000;
  logic [31:0] last_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic busy_at(input int e);
    return (e - last_mul) < (MUL_LAT - 1);
  endfunction

  task automatic model_reset();
    m = '0;
    last_mul = -1000;
  endtask

  // Present one ID cycle at the negedge and record what must follow.
  task automatic issue(input logic v, input ctrl c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm, input logic hold, input logic fl);
    ex_regs n;
    logic   lu, mb;
    int     s;
    @(negedge clk);
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
    id_immed = imm; ex_hold = hold; flush = fl;
    id_rs_val = $urandom; id_rt_val = $urandom; id_pc = $urandom;
    last_pc = id_pc;

    lu = m.valid && m.ctrl.WRITE_REG && m.ctrl.ALUORMEM_WR && (m.wa != 0) &&
         v && (m.wa == rs || m.wa == rt);
    mb = v && c.MULTIPLY && busy_at(edges);
    stall_q.push_back(hold || lu || mb);

    n = '0;
    if (fl)            n = '0;
    else if (hold)     n = m;
    else if (lu || mb) n = '0;
    else if (v) begin
      n.valid = 1'b1; n.ctrl = c; n.rs = rs; n.rt = rt;
      n.rs_val = id_rs_val; n.rt_val = id_rt_val; n.pc = id_pc;
      if (c.REG_DST == 2'd0)      n.wa = rt;
      else if (c.REG_DST == 2'd1) n.wa = rd;
      else                        n.wa = 5'd31;
      if (c.IMMED_EXT == 2'd1) begin
        s = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
        n.imm = s;
      end else if (c.IMMED_EXT == 2'd2) n.imm = 32'(imm) * 65536;
      else                              n.imm = 32'(imm);
      if (c.MULTIPLY) last_mul = edges + 1;
    end
    edges++;
    m = n;
    ex_q.push_back(n);
    busy_q.push_back(busy_at(edges));
  endtask

  // Monitor: combinational stall for the inputs presented this cycle.
  initial forever begin
    @(negedge clk); #2;
    if (stall_q.size() > 0) chk("stall_id", 32'(stall_id), 32'(stall_q.pop_front()));
  end

  // Monitor: EX register contents after each edge.
  initial forever begin
    ex_regs e;
    logic   b;
    @(posedge clk); #1;
    if (ex_q.size() > 0) begin
      e = ex_q.pop_front();
      b = busy_q.pop_front();
      chk("ex_valid",  32'(ex_valid),  32'(e.valid));
      chk("ex_ctrl",   32'(ex_ctrl),   32'(e.ctrl));
      chk("ex_wa",     32'(ex_wa),     32'(e.wa));
      chk("ex_rs",     32'(ex_rs),     32'(e.rs));
      chk("ex_rt",     32'(ex_rt),     32'(e.rt));
      chk("ex_rs_val", ex_rs_val,      e.rs_val);
      chk("ex_rt_val", ex_rt_val,      e.rt_val);
      chk("ex_imm",    ex_imm,         e.imm);
      chk("ex_pc",     ex_pc,          e.pc);
      chk("mul_busy",  32'(mul_busy),  32'(b));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_ctrl"},  32'(ex_ctrl),  32'd0);
    chk({tag, "_pc"},    ex_pc,         32'd0);
    chk({tag, "_wa"},    32'(ex_wa),    32'd0);
    chk({tag, "_stall"}, 32'(stall_id), 32'd0);
    chk({tag, "_busy"},  32'(mul_busy), 32'd0);
  endtask

  initial begin
    ctrl c, lw, add, mul, nop;
    logic [30:0] raw;
    logic [31:0] held_pc;
    model_reset();
    #12;
    reset_checks("rst");
    @(negedge clk); reset = 1'b0;

    nop = '0;
    lw = '0;  lw.WRITE_REG = 1'b1; lw.ALUORMEM_WR = 1'b1; lw.REG_DST = REG_DST_RT;
    add = '0; add.WRITE_REG = 1'b1; add.REG_DST = REG_DST_RD;
    mul = '0; mul.MULTIPLY = 1'b1;

    // Load-use: one bubble, then the add goes through.
    issue(1, lw,  5'd1, 5'd5, 5'd0, 16'h0, 0, 0);
    issue(1, add, 5'd5, 5'd2, 5'd7, 16'h0, 0, 0);
    after_edge(); chk("lu_bubble", 32'(ex_valid), 32'd0);
    issue(1, add, 5'd5, 5'd2, 5'd7, 16'h0, 0, 0);
    after_edge(); chk("lu_accept", 32'(ex_valid), 32'd1);
    chk("lu_accept_wa", 32'(ex_wa), 32'd7);
    // Destination r0 never interlocks.
    issue(1, lw,  5'd1, 5'd0, 5'd0, 16'h0, 0, 0);
    issue(1, add, 5'd0, 5'd0, 5'd3, 16'h0, 0, 0);
    after_edge(); chk("r0_no_stall", 32'(ex_valid), 32'd1);

    // Multiply interlock: three bubbles, then the second mult issues.
    issue(1, mul, 5'd1, 5'd2, 5'd0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) issue(1, mul, 5'd1, 5'd2, 5'd0, 16'h0, 0, 0);
    after_edge(); chk("mul_3rd_bubble", 32'(ex_valid), 32'd0);
    issue(1, mul, 5'd1, 5'd2, 5'd0, 16'h0, 0, 0);
    after_edge(); chk("mul_second_issue", 32'(ex_valid), 32'd1);
    chk("mul_busy_rearmed", 32'(mul_busy), 32'd1);
    for (int i = 0; i < 3; i++) issue(0, nop, 5'd0, 5'd0, 5'd0, 16'h0, 0, 0);

    // Flush beats hold; hold alone freezes EX.
    issue(1, add, 5'd1, 5'd2, 5'd3, 16'h0, 0, 0);
    issue(1, add, 5'd1, 5'd2, 5'd3, 16'h0, 1, 1);
    after_edge(); chk("flush_hold_valid", 32'(ex_valid), 32'd0);
    issue(1, add, 5'd1, 5'd2, 5'd4, 16'h0, 0, 0);
    held_pc = last_pc;
    for (int i = 0; i < 3; i++) issue(1, add, 5'd9, 5'd9, 5'd9, 16'h1234, 1, 0);
    after_edge(); chk("hold_pc", ex_pc, held_pc);
    chk("hold_wa", 32'(ex_wa), 32'd4);

    // Field resolution.
    c = '0; c.IMMED_EXT = IMM_SIGN;
    issue(1, c, 5'd0, 5'd0, 5'd0, 16'h8001, 0, 0);
    after_edge(); chk("imm_sign", ex_imm, 32'hFFFF8001);
    c.IMMED_EXT = IMM_UPPER;
    issue(1, c, 5'd0, 5'd0, 5'd0, 16'h8001, 0, 0);
    after_edge(); chk("imm_upper", ex_imm, 32'h80010000);
    c.IMMED_EXT = 2'b11;
    issue(1, c, 5'd0, 5'd0, 5'd0, 16'h8001, 0, 0);
    after_edge(); chk("imm_11_zero", ex_imm, 32'h00008001);
    c = '0; c.REG_DST = REG_DST_RA;
    issue(1, c, 5'd0, 5'd3, 5'd9, 16'h0, 0, 0);
    after_edge(); chk("wa_ra", 32'(ex_wa), 32'd31);
    c.REG_DST = REG_DST_RD;
    issue(1, c, 5'd0, 5'd3, 5'd9, 16'h0, 0, 0);
    after_edge(); chk("wa_rd", 32'(ex_wa), 32'd9);

    // Invalid instruction carrying a store bit becomes a clean bubble.
    c = '0; c.WRITE_MEM = 1'b1;
    issue(0, c, 5'd0, 5'd0, 5'd0, 16'h0, 0, 0);
    after_edge(); chk("invalid_ctrl", 32'(ex_ctrl), 32'd0);

    // Asynchronous reset with a valid instruction and a busy multiplier.
    issue(1, mul, 5'd1, 5'd2, 5'd0, 16'h0, 0, 0);
    @(posedge clk); #2;
    reset = 1'b1; #1;
    reset_checks("async_rst");
    model_reset();
    #1 reset = 1'b0;
    issue(1, add, 5'd1, 5'd2, 5'd6, 16'h0, 0, 0);
    after_edge(); chk("post_rst_accept", 32'(ex_wa), 32'd6);

    // Randomized traffic with frequent hazards.
    for (int i = 0; i < 400; i++) begin
      raw = 31'($urandom);
      c = raw;
      c.MULTIPLY = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin c.WRITE_REG = 1'b1; c.ALUORMEM_WR = 1'b1; end
      issue($urandom_range(0, 4) != 0, c,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            16'($urandom), $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("queues_drained", 32'(stall_q.size() + ex_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
